// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register bank write port between ALU and LSU.
// One holding register per requester, round-robin drain into a write stage.
module rf_wr_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          lsu_valid,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  output logic          lsu_ready,
  input  logic          flush,
  input  logic [AW-1:0] DIR_A,
  input  logic [AW-1:0] DIR_B,
  output logic          REG_WR,
  output logic [AW-1:0] DIR_WR,
  output logic [DW-1:0] DI,
  output logic          pend_a,
  output logic          pend_b
);

  logic          alu_hv_q, alu_hv_d;
  logic [AW-1:0] alu_rd_q, alu_rd_d;
  logic [DW-1:0] alu_dt_q, alu_dt_d;
  logic          lsu_hv_q, lsu_hv_d;
  logic [AW-1:0] lsu_rd_q, lsu_rd_d;
  logic [DW-1:0] lsu_dt_q, lsu_dt_d;
  logic          rr_q, rr_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] dir_q, dir_d;
  logic [DW-1:0] di_q, di_d;

  logic grant_alu, grant_lsu;
  logic cap_alu, cap_lsu;

  // Round-robin grant and handshake readiness (rr=1 prefers LSU).
  always_comb begin
    grant_alu = alu_hv_q & (~lsu_hv_q | ~rr_q);
    grant_lsu = lsu_hv_q & (~alu_hv_q | rr_q);
    alu_ready = ~rst & (~alu_hv_q | grant_alu);
    lsu_ready = ~rst & (~lsu_hv_q | grant_lsu);
    cap_alu   = alu_valid & alu_ready & (alu_rd != '0);
    cap_lsu   = lsu_valid & lsu_ready & (lsu_rd != '0);
  end

  // Next state for holds, arbiter pointer and write stage.
  always_comb begin
    alu_hv_d = alu_hv_q;
    alu_rd_d = alu_rd_q;
    alu_dt_d = alu_dt_q;
    lsu_hv_d = lsu_hv_q;
    lsu_rd_d = lsu_rd_q;
    lsu_dt_d = lsu_dt_q;
    rr_d     = rr_q;
    wr_d     = grant_alu | grant_lsu;
    dir_d    = dir_q;
    di_d     = di_q;

    if (grant_alu) begin
      alu_hv_d = 1'b0;
      rr_d     = 1'b1;
      dir_d    = alu_rd_q;
      di_d     = alu_dt_q;
    end
    if (grant_lsu) begin
      lsu_hv_d = 1'b0;
      rr_d     = 1'b0;
      dir_d    = lsu_rd_q;
      di_d     = lsu_dt_q;
    end

    if (cap_alu) begin
      alu_hv_d = 1'b1;
      alu_rd_d = alu_rd;
      alu_dt_d = alu_data;
    end
    if (cap_lsu) begin
      lsu_hv_d = 1'b1;
      lsu_rd_d = lsu_rd;
      lsu_dt_d = lsu_data;
    end

    // Flush wins over refill; the grant made this cycle still completes.
    if (flush) begin
      alu_hv_d = 1'b0;
      lsu_hv_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_hv_q <= 1'b0;
      alu_rd_q <= '0;
      alu_dt_q <= '0;
      lsu_hv_q <= 1'b0;
      lsu_rd_q <= '0;
      lsu_dt_q <= '0;
      rr_q     <= 1'b1;
      wr_q     <= 1'b0;
      dir_q    <= '0;
      di_q     <= '0;
    end else begin
      alu_hv_q <= alu_hv_d;
      alu_rd_q <= alu_rd_d;
      alu_dt_q <= alu_dt_d;
      lsu_hv_q <= lsu_hv_d;
      lsu_rd_q <= lsu_rd_d;
      lsu_dt_q <= lsu_dt_d;
      rr_q     <= rr_d;
      wr_q     <= wr_d;
      dir_q    <= dir_d;
      di_q     <= di_d;
    end
  end

  // Pending-write lookup over both holds and the write stage.
  always_comb begin
    pend_a = (DIR_A != '0) &&
             ((alu_hv_q && alu_rd_q == DIR_A) ||
              (lsu_hv_q && lsu_rd_q == DIR_A) ||
              (wr_q && dir_q == DIR_A));
    pend_b = (DIR_B != '0) &&
             ((alu_hv_q && alu_rd_q == DIR_B) ||
              (lsu_hv_q && lsu_rd_q == DIR_B) ||
              (wr_q && dir_q == DIR_B));
  end

  assign REG_WR = wr_q;
  assign DIR_WR = dir_q;
  assign DI     = di_q;

endmodule
